// File: rtl/mem_stage_if.sv
// EX/MEM-to-MEM bundle: pipeline register outputs in, redirect,
// forwarding and MEM/WB results out.
interface mem_stage_if;
    logic [31:0] rs2;
    logic [31:0] immPc;
    logic [31:0] pcAdd4;
    logic [31:0] outAlu;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        EscReg;
    logic        EscMem;
    logic        jump;
    logic        Branch;
    logic        lui;
    logic        jalr;
    logic        lw;

    logic        pcSrc;
    logic [31:0] pcTarget;
    logic [31:0] wbData;
    logic [4:0]  rdOut;
    logic        EscRegOut;
    logic        misalignOut;
    logic [4:0]  memFwdRd;
    logic        memFwdEn;

    modport master (
        output rs2, immPc, pcAdd4, outAlu, imm, rd,
        output EscReg, EscMem, jump, Branch, lui, jalr, lw,
        input  pcSrc, pcTarget, wbData, rdOut,
        input  EscRegOut, misalignOut, memFwdRd, memFwdEn
    );

    modport slave (
        input  rs2, immPc, pcAdd4, outAlu, imm, rd,
        input  EscReg, EscMem, jump, Branch, lui, jalr, lw,
        output pcSrc, pcTarget, wbData, rdOut,
        output EscRegOut, misalignOut, memFwdRd, memFwdEn
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: word data memory, control-flow redirect,
// write-back select and the MEM/WB register.
module mem_stage #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    mem_stage_if.slave bus
);

    logic [31:0]       r_mem [DEPTH];
    logic [31:0]       r_wbData;
    logic [4:0]        r_rdOut;
    logic              r_escRegOut;
    logic              r_misalign;

    logic [ADDR_W-1:0] w_idx;
    logic              w_memOp;
    logic              w_misalign;
    logic              w_store;
    logic              w_regWr;
    logic [31:0]       w_rdata;
    logic [31:0]       w_wbNext;
    logic              w_pcSrc;
    logic [31:0]       w_pcTarget;
    logic              w_unused_addr;

    // Upper address bits are dropped, so accesses wrap modulo DEPTH*4.
    assign w_idx         = bus.outAlu[ADDR_W+1:2];
    assign w_unused_addr = ^bus.outAlu[31:ADDR_W+2];

    assign w_memOp    = bus.lw | bus.EscMem;
    assign w_misalign = w_memOp & (bus.outAlu[1:0] != 2'b00);
    assign w_store    = bus.EscMem & ~w_misalign;
    assign w_rdata    = r_mem[w_idx];

    assign w_regWr = bus.EscReg
                   & (bus.rd != 5'd0)
                   & ~(bus.lw & w_misalign);

    // Overlapping flags are legal here; the if-chain fixes priority.
    always_comb begin
        w_pcSrc    = 1'b0;
        w_pcTarget = bus.pcAdd4;
        if (bus.jalr) begin
            w_pcSrc    = 1'b1;
            w_pcTarget = bus.outAlu & 32'hFFFF_FFFE;
        end else if (bus.jump | bus.Branch) begin
            w_pcSrc    = 1'b1;
            w_pcTarget = bus.immPc;
        end
    end

    always_comb begin
        w_wbNext = bus.outAlu;
        if (bus.lw) begin
            w_wbNext = w_rdata;
        end else if (bus.jump | bus.jalr) begin
            w_wbNext = bus.pcAdd4;
        end else if (bus.lui) begin
            w_wbNext = bus.imm;
        end
    end

    // The array is never cleared; reset only blocks the write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wbData    <= 32'd0;
            r_rdOut     <= 5'd0;
            r_escRegOut <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_wbData    <= w_wbNext;
            r_rdOut     <= bus.rd;
            r_escRegOut <= w_regWr;
            r_misalign  <= w_misalign;
            if (w_store) begin
                r_mem[w_idx] <= bus.rs2;
            end
        end
    end

    assign bus.pcSrc       = w_pcSrc;
    assign bus.pcTarget    = w_pcTarget;
    assign bus.wbData      = r_wbData;
    assign bus.rdOut       = r_rdOut;
    assign bus.EscRegOut   = r_escRegOut;
    assign bus.misalignOut = r_misalign;
    assign bus.memFwdRd    = bus.rd;
    assign bus.memFwdEn    = bus.EscReg & (bus.rd != 5'd0) & ~bus.lw;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, directed
// multi-cycle sequences and a random run against a reference model.
module tb_mem_stage;

    localparam int DEPTH = 256;

    localparam bit [6:0] C_REG  = 7'b1000000;
    localparam bit [6:0] C_MEM  = 7'b0100000;
    localparam bit [6:0] C_JAL  = 7'b0010000;
    localparam bit [6:0] C_BR   = 7'b0001000;
    localparam bit [6:0] C_LUI  = 7'b0000100;
    localparam bit [6:0] C_JALR = 7'b0000010;
    localparam bit [6:0] C_LW   = 7'b0000001;

    typedef struct {
        logic [31:0] rs2;
        logic [31:0] immPc;
        logic [31:0] pcAdd4;
        logic [31:0] outAlu;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        EscReg;
        logic        EscMem;
        logic        jump;
        logic        Branch;
        logic        lui;
        logic        jalr;
        logic        lw;
    } in_t;

    typedef struct {
        logic        pcSrc;
        logic [31:0] pcTarget;
        logic [31:0] wb;
        logic        esc;
        logic        mis;
        logic        fwdEn;
    } exp_t;

    typedef struct {
        in_t  in;
        exp_t ex;
    } vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    logic [31:0] mdl_mem [DEPTH];
    vec_t        tbl [12];

    mem_stage_if bus ();

    mem_stage #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic in_t mk_in(input logic [31:0] rs2,
                                  input logic [31:0] immPc,
                                  input logic [31:0] pcAdd4,
                                  input logic [31:0] outAlu,
                                  input logic [31:0] imm,
                                  input logic [4:0] rd,
                                  input logic [6:0] ctl);
        in_t v;
        v.rs2    = rs2;
        v.immPc  = immPc;
        v.pcAdd4 = pcAdd4;
        v.outAlu = outAlu;
        v.imm    = imm;
        v.rd     = rd;
        v.EscReg = ctl[6];
        v.EscMem = ctl[5];
        v.jump   = ctl[4];
        v.Branch = ctl[3];
        v.lui    = ctl[2];
        v.jalr   = ctl[1];
        v.lw     = ctl[0];
        return v;
    endfunction

    function automatic exp_t model(input in_t v);
        exp_t        e;
        int unsigned idx;
        bit          mis;
        idx = (v.outAlu / 4) % DEPTH;
        mis = (v.lw || v.EscMem) && ((v.outAlu % 4) != 0);
        if (v.jalr) begin
            e.pcSrc    = 1'b1;
            e.pcTarget = v.outAlu - (v.outAlu % 2);
        end else if (v.jump || v.Branch) begin
            e.pcSrc    = 1'b1;
            e.pcTarget = v.immPc;
        end else begin
            e.pcSrc    = 1'b0;
            e.pcTarget = v.pcAdd4;
        end
        if (v.lw)                 e.wb = mdl_mem[idx];
        else if (v.jump || v.jalr) e.wb = v.pcAdd4;
        else if (v.lui)           e.wb = v.imm;
        else                      e.wb = v.outAlu;
        e.esc   = v.EscReg && (v.rd != 0) && !(v.lw && mis);
        e.mis   = mis;
        e.fwdEn = v.EscReg && (v.rd != 0) && !v.lw;
        return e;
    endfunction

    task automatic drive(input in_t v);
        bus.rs2    = v.rs2;
        bus.immPc  = v.immPc;
        bus.pcAdd4 = v.pcAdd4;
        bus.outAlu = v.outAlu;
        bus.imm    = v.imm;
        bus.rd     = v.rd;
        bus.EscReg = v.EscReg;
        bus.EscMem = v.EscMem;
        bus.jump   = v.jump;
        bus.Branch = v.Branch;
        bus.lui    = v.lui;
        bus.jalr   = v.jalr;
        bus.lw     = v.lw;
    endtask

    task automatic do_cycle(input in_t v, input exp_t e,
                            input string tag);
        @(negedge clk);
        drive(v);
        #1;
        chk({tag, ".pcSrc"}, {31'd0, bus.pcSrc}, {31'd0, e.pcSrc});
        chk({tag, ".pcTarget"}, bus.pcTarget, e.pcTarget);
        chk({tag, ".fwdEn"}, {31'd0, bus.memFwdEn}, {31'd0, e.fwdEn});
        chk({tag, ".fwdRd"}, {27'd0, bus.memFwdRd}, {27'd0, v.rd});
        @(posedge clk);
        #1;
        chk({tag, ".wbData"}, bus.wbData, e.wb);
        chk({tag, ".EscRegOut"}, {31'd0, bus.EscRegOut}, {31'd0, e.esc});
        chk({tag, ".misalign"}, {31'd0, bus.misalignOut}, {31'd0, e.mis});
        chk({tag, ".rdOut"}, {27'd0, bus.rdOut}, {27'd0, v.rd});
    endtask

    task automatic run(input in_t v, input string tag);
        exp_t e;
        e = model(v);
        do_cycle(v, e, tag);
        if (v.EscMem && ((v.outAlu % 4) == 0))
            mdl_mem[(v.outAlu / 4) % DEPTH] = v.rs2;
    endtask

    task automatic chk_regs_zero(input string tag);
        chk({tag, ".wbData"}, bus.wbData, 32'd0);
        chk({tag, ".EscRegOut"}, {31'd0, bus.EscRegOut}, 32'd0);
        chk({tag, ".rdOut"}, {27'd0, bus.rdOut}, 32'd0);
        chk({tag, ".misalign"}, {31'd0, bus.misalignOut}, 32'd0);
    endtask

    initial begin
        in_t  v;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        drive(mk_in(0, 0, 0, 0, 0, 0, 7'd0));

        // {inputs} -> {pcSrc, pcTarget, wb, esc, mis, fwdEn}
        tbl[0].in  = mk_in(0, 32'h200, 32'h84, 32'h1003, 0, 1, C_REG | C_JALR);
        tbl[0].ex  = '{1'b1, 32'h1002, 32'h84, 1'b1, 1'b0, 1'b1};
        tbl[1].in  = mk_in(0, 32'h40, 32'h88, 32'h1, 0, 0, C_BR);
        tbl[1].ex  = '{1'b1, 32'h40, 32'h1, 1'b0, 1'b0, 1'b0};
        tbl[2].in  = mk_in(0, 32'h300, 32'h104, 32'h7, 0, 1, C_REG | C_JAL);
        tbl[2].ex  = '{1'b1, 32'h300, 32'h104, 1'b1, 1'b0, 1'b1};
        tbl[3].in  = mk_in(0, 0, 32'h10, 32'h99, 32'hABCDE000, 7, C_REG | C_LUI);
        tbl[3].ex  = '{1'b0, 32'h10, 32'hABCDE000, 1'b1, 1'b0, 1'b1};
        tbl[4].in  = mk_in(0, 0, 32'h10, 32'h99, 32'hABCDE000, 0, C_REG | C_LUI);
        tbl[4].ex  = '{1'b0, 32'h10, 32'hABCDE000, 1'b0, 1'b0, 1'b0};
        tbl[5].in  = mk_in(0, 32'h3333, 32'h2222, 32'h9, 32'h1111, 2,
                           C_REG | C_LUI | C_JAL);
        tbl[5].ex  = '{1'b1, 32'h3333, 32'h2222, 1'b1, 1'b0, 1'b1};
        tbl[6].in  = mk_in(0, 32'h700, 32'h60, 32'h501, 0, 4,
                           C_REG | C_JALR | C_JAL);
        tbl[6].ex  = '{1'b1, 32'h500, 32'h60, 1'b1, 1'b0, 1'b1};
        tbl[7].in  = mk_in(0, 32'h80, 32'h44, 32'h55, 32'h66, 0, 7'd0);
        tbl[7].ex  = '{1'b0, 32'h44, 32'h55, 1'b0, 1'b0, 1'b0};
        tbl[8].in  = mk_in(0, 0, 32'h8, 32'h10, 0, 5, C_REG | C_LW);
        tbl[8].ex  = '{1'b0, 32'h8, 32'hC0DE0004, 1'b1, 1'b0, 1'b0};
        tbl[9].in  = mk_in(0, 0, 32'hC, 32'h21, 0, 3, C_REG | C_LW);
        tbl[9].ex  = '{1'b0, 32'hC, 32'hC0DE0008, 1'b0, 1'b1, 1'b0};
        tbl[10].in = mk_in(0, 0, 32'h20, 32'hFFFFFFF2, 0, 31, C_REG);
        tbl[10].ex = '{1'b0, 32'h20, 32'hFFFFFFF2, 1'b1, 1'b0, 1'b1};
        tbl[11].in = mk_in(32'h12345678, 0, 32'h24, 32'h22, 0, 0, C_MEM);
        tbl[11].ex = '{1'b0, 32'h24, 32'h22, 1'b0, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        chk_regs_zero("reset");
        reset = 1'b1;

        for (int i = 0; i < DEPTH; i++)
            run(mk_in(32'hC0DE0000 + i, 0, 0, i * 4, 0, 0, C_MEM), "init");

        for (int i = 0; i < 12; i++)
            do_cycle(tbl[i].in, tbl[i].ex, $sformatf("vec%0d", i));

        // Asynchronous reset mid-cycle, with a store blocked by it.
        run(mk_in(0, 0, 0, 32'h1234, 0, 9, C_REG), "pre_rst");
        #2 reset = 1'b0;
        #1 chk_regs_zero("async_rst");
        @(negedge clk);
        drive(mk_in(32'h00000BAD, 0, 0, 32'h30, 0, 0, C_MEM));
        @(posedge clk);
        #1 chk_regs_zero("rst_hold");
        @(negedge clk);
        reset = 1'b1;
        drive(mk_in(0, 0, 0, 0, 0, 0, 7'd0));
        run(mk_in(0, 0, 0, 32'h10, 0, 5, C_REG | C_LW), "post_rst_lw");
        run(mk_in(0, 0, 0, 32'h30, 0, 6, C_REG | C_LW), "rst_store_drop");
        chk("rst_store_drop.const", bus.wbData, 32'hC0DE000C);

        run(mk_in(32'hDEADBEEF, 0, 0, 32'h20, 0, 0, C_MEM), "st20");
        run(mk_in(0, 0, 0, 32'h20, 0, 4, C_REG | C_LW), "ld20");
        chk("ld20.const", bus.wbData, 32'hDEADBEEF);
        run(mk_in(0, 0, 0, 32'h420, 0, 4, C_REG | C_LW), "ld_wrap");
        chk("ld_wrap.const", bus.wbData, 32'hDEADBEEF);
        run(mk_in(32'h0BADF00D, 0, 0, 32'h22, 0, 0, C_MEM), "st_mis");
        run(mk_in(0, 0, 0, 32'h20, 0, 4, C_REG | C_LW), "ld_after_mis");
        chk("ld_after_mis.const", bus.wbData, 32'hDEADBEEF);
        run(mk_in(0, 0, 0, 32'h21, 0, 3, C_REG | C_LW), "ld_mis");

        for (int i = 0; i < 400; i++) begin
            logic [6:0] ctl;
            ctl = 7'($urandom);
            if (ctl[5] && ctl[0]) ctl[5] = 1'b0;
            v = mk_in($urandom, $urandom, $urandom, $urandom, $urandom,
                      5'($urandom), ctl);
            if ($urandom_range(3) != 0) v.outAlu[1:0] = 2'b00;
            run(v, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
